// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop input synchronizer, oversampling tick generator,
// mid-bit sampling FSM and a single-entry output holding register with
// acknowledge, framing-error and overrun-error reporting.
module uart_rx #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk_50m,
    input  logic       reset_n,
    input  logic       Rx,
    input  logic       data_ack,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       rx_busy,
    output logic       framing_err,
    output logic       overrun_err
);

    localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OW  = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
    localparam logic [OW-1:0] OS_LAST   = OW'(OVERSAMPLE - 1);
    localparam logic [OW-1:0] OS_HALF   = OW'(OVERSAMPLE / 2 - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t          state, state_nxt;
    logic            rx_meta, rx_sync;
    logic [TW-1:0]   tick_cnt;
    logic            tick;
    logic [OW-1:0]   os_cnt;
    logic            os_wrap;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift_reg;
    logic            start_det, sample_bit, accept, frame_bad;

    assign tick    = (tick_cnt == TICK_LAST);
    // START decides at the half-bit point; DATA/STOP sample one full bit later
    assign os_wrap = tick && (os_cnt == ((state == START) ? OS_HALF : OS_LAST));
    assign rx_busy = (state != IDLE);

    // Two-flop synchronizer; idles at 1 so reset looks like an idle line
    always_ff @(posedge clk_50m or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= Rx;
            rx_sync <= rx_meta;
        end
    end

    // Tick generator: free-runs, realigned to the detected start edge
    always_ff @(posedge clk_50m or negedge reset_n) begin
        if (!reset_n)
            tick_cnt <= '0;
        else if (start_det || tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + 1'b1;
    end

    // State register
    always_ff @(posedge clk_50m or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state and per-cycle strobes
    always_comb begin
        state_nxt  = state;
        start_det  = 1'b0;
        sample_bit = 1'b0;
        accept     = 1'b0;
        frame_bad  = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_sync) begin
                    start_det = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                // a start bit that is high again at mid-bit was a glitch
                if (os_wrap)
                    state_nxt = rx_sync ? IDLE : DATA;
            end
            DATA: begin
                if (os_wrap) begin
                    sample_bit = 1'b1;
                    if (bit_cnt == 3'd7)
                        state_nxt = STOP;
                end
            end
            STOP: begin
                if (os_wrap) begin
                    if (rx_sync) begin
                        accept    = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        frame_bad = 1'b1;
                        state_nxt = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                // stay here through a break until the line returns high
                if (rx_sync)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Oversample counter, bit counter and LSB-first shift register
    always_ff @(posedge clk_50m or negedge reset_n) begin
        if (!reset_n) begin
            os_cnt    <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else begin
            if (state == IDLE || state == WAIT_HIGH || os_wrap)
                os_cnt <= '0;
            else if (tick)
                os_cnt <= os_cnt + 1'b1;

            if (state != DATA)
                bit_cnt <= '0;
            else if (sample_bit)
                bit_cnt <= bit_cnt + 3'd1;

            if (sample_bit)
                shift_reg <= {rx_sync, shift_reg[7:1]};
        end
    end

    // Output holding register and error pulses
    always_ff @(posedge clk_50m or negedge reset_n) begin
        if (!reset_n) begin
            data_out    <= '0;
            data_valid  <= 1'b0;
            framing_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            framing_err <= frame_bad;
            overrun_err <= 1'b0;
            if (accept) begin
                // an ack in the same cycle frees the slot for the new byte
                if (!data_valid || data_ack) begin
                    data_out   <= shift_reg;
                    data_valid <= 1'b1;
                end else begin
                    overrun_err <= 1'b1;
                end
            end else if (data_ack) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized bench for uart_rx with a frame-level reference model.
module tb_uart_rx;

    localparam int DIVV = 50000000 / (115200 * 16);
    localparam int BIT  = DIVV * 16;
    // Rx driven just after edge 0: two synchronizer edges, one detect edge,
    // then 8 + 9*16 ticks to the stop-bit sample; outputs update on that edge.
    localparam int ACC  = 3 + DIVV * (8 + 9 * 16);

    logic       clk_50m = 1'b0;
    logic       reset_n = 1'b0;
    logic       Rx = 1'b1;
    logic       data_ack = 1'b0;
    logic [7:0] data_out;
    logic       data_valid, rx_busy, framing_err, overrun_err;

    int n_cmp = 0, n_err = 0;
    int frm_seen = 0, ovr_seen = 0;

    logic [7:0] exp_data = 8'h00;
    logic       exp_valid = 1'b0;
    int         exp_frm = 0, exp_ovr = 0;

    uart_rx dut (
        .clk_50m(clk_50m), .reset_n(reset_n), .Rx(Rx), .data_ack(data_ack),
        .data_out(data_out), .data_valid(data_valid), .rx_busy(rx_busy),
        .framing_err(framing_err), .overrun_err(overrun_err)
    );

    always #10 clk_50m = ~clk_50m;

    // count error pulses in high cycles, so a stretched pulse counts twice
    always @(negedge clk_50m) begin
        if (framing_err) frm_seen <= frm_seen + 1;
        if (overrun_err) ovr_seen <= ovr_seen + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(posedge clk_50m);
        #1;
    endtask

    task automatic check_model(input bit idle_chk);
        chk("data_out", data_out, exp_data);
        chk("data_valid", data_valid, exp_valid);
        chk("framing_cnt", frm_seen, exp_frm);
        chk("overrun_cnt", ovr_seen, exp_ovr);
        if (idle_chk) chk("busy_idle", rx_busy, 0);
    endtask

    task automatic do_ack();
        @(posedge clk_50m); #1;
        data_ack = 1'b1;
        clk_n(1);
        data_ack = 1'b0;
        exp_valid = 1'b0;
    endtask

    // One 8N1 frame. ack_win raises data_ack on the two edges ending at the
    // acceptance edge; low_hold keeps the line low after the stop bit.
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic ack_win,
                              input int low_hold, input int gap);
        logic [8:0] bits;
        bits = {b, 1'b0};
        @(posedge clk_50m); #1;
        for (int i = 0; i < 9; i++) begin
            Rx = bits[i];
            if (i == 5) begin
                clk_n(BIT / 2);
                chk("busy_mid", rx_busy, 1);
                clk_n(BIT - BIT / 2);
            end else begin
                clk_n(BIT);
            end
        end
        Rx = stop;
        clk_n(ACC - 2 - 9 * BIT);
        if (ack_win) data_ack = 1'b1;
        clk_n(2);
        data_ack = 1'b0;
        if (stop) begin
            if (!exp_valid || ack_win) begin
                exp_data  = b;
                exp_valid = 1'b1;
            end else begin
                exp_ovr++;
            end
        end else begin
            exp_frm++;
            if (ack_win) exp_valid = 1'b0;
        end
        chk("dv_at_accept", data_valid, exp_valid);
        chk("dout_at_accept", data_out, exp_data);
        clk_n(10 * BIT - ACC);
        if (low_hold > 0) begin
            clk_n(low_hold / 2);
            chk("busy_wait_high", rx_busy, 1);
            clk_n(low_hold - low_hold / 2);
        end
        Rx = 1'b1;
        clk_n(gap);
    endtask

    initial begin
        logic [7:0] rb;
        logic       rs, ra;

        // reset state, asserted from time 0
        #5;
        chk("rst_dout", data_out, 0);
        chk("rst_dv", data_valid, 0);
        chk("rst_busy", rx_busy, 0);
        chk("rst_frm", framing_err, 0);
        chk("rst_ovr", overrun_err, 0);
        clk_n(3);
        reset_n = 1'b1;
        clk_n(5);

        // basic frame
        send_frame(8'hA5, 1'b1, 1'b0, 0, 10);
        check_model(1'b1);

        // back-to-back 0x00 / 0xFF with ack after each
        do_ack();
        send_frame(8'h00, 1'b1, 1'b0, 0, 0);
        do_ack();
        send_frame(8'hFF, 1'b1, 1'b0, 0, 0);
        chk("b2b_dout", data_out, 8'hFF);
        do_ack();
        check_model(1'b1);

        // short low glitch is rejected
        @(posedge clk_50m); #1;
        Rx = 1'b0;
        clk_n(100);
        Rx = 1'b1;
        clk_n(300);
        check_model(1'b1);

        // bad stop bit followed by a long break
        send_frame(8'h3C, 1'b0, 1'b0, 2000, 20);
        check_model(1'b1);

        // overrun, then same pair with ack on the acceptance cycle
        send_frame(8'h11, 1'b1, 1'b0, 0, 5);
        send_frame(8'h22, 1'b1, 1'b0, 0, 5);
        chk("ovr_keep_dout", data_out, 8'h11);
        check_model(1'b1);
        do_ack();
        send_frame(8'h11, 1'b1, 1'b0, 0, 5);
        send_frame(8'h22, 1'b1, 1'b1, 0, 5);
        chk("ack_load_dout", data_out, 8'h22);
        check_model(1'b1);

        // randomized frames against the model
        for (int k = 0; k < 5; k++) begin
            rb = 8'($urandom_range(0, 255));
            rs = ($urandom_range(0, 3) != 0);
            ra = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) do_ack();
            send_frame(rb, rs, ra, 0, rs ? int'($urandom_range(4, 40)) : 20 + int'($urandom_range(0, 40)));
            check_model(1'b1);
        end

        // reset during data bit 4 while an unacknowledged byte is held
        if (!exp_valid) send_frame(8'hC3, 1'b1, 1'b0, 0, 10);
        rb = 8'h96;
        @(posedge clk_50m); #1;
        Rx = 1'b0;
        clk_n(BIT);
        for (int i = 0; i < 4; i++) begin
            Rx = rb[i];
            clk_n(BIT);
        end
        Rx = rb[4];
        clk_n(BIT / 2);
        reset_n = 1'b0;
        #2;
        chk("mid_rst_dout", data_out, 0);
        chk("mid_rst_dv", data_valid, 0);
        chk("mid_rst_busy", rx_busy, 0);
        chk("mid_rst_frm", framing_err, 0);
        chk("mid_rst_ovr", overrun_err, 0);
        exp_data  = 8'h00;
        exp_valid = 1'b0;
        clk_n(5);
        Rx = 1'b1;
        reset_n = 1'b1;
        clk_n(2 * BIT);
        check_model(1'b1);
        send_frame(8'h5A, 1'b1, 1'b0, 0, 10);
        chk("post_rst_dout", data_out, 8'h5A);
        check_model(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
